mio_arbiter: RTL
================

MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 Parameter AW, 32, address width of all address ports.
REQ-002 Parameter DW, 32, data width of all data ports.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port m0_req / m0_we  input  1 each  CPU memory request / write enable (CPU is master 0).
REQ-006 Port m0_addr / m0_wdata  input  AW / DW  CPU address / write data.
REQ-007 Port m0_rdata / m0_ready  output  DW / 1  CPU read data / one-cycle completion pulse.
REQ-008 Port m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready  same directions and widths as m0_*  second master (audio/VGA fetch engine).
REQ-009 Port s_req / s_we  output  1 each  shared memory request / write enable.
REQ-010 Port s_addr / s_wdata  output  AW / DW  shared memory address / write data.
REQ-011 Port s_rdata / s_ack  input  DW / 1  shared memory read data / completion strobe.
REQ-012 Port grant  output  2  one-hot owner of the bus: bit0 = m0, bit1 = m1, 00 = none.
REQ-013 Port state_out  output  2  current FSM state encoding, for debug.

Function
REQ-014 FSM states SHALL be IDLE=2'd0, BUS=2'd1, DONE=2'd2; encoding 2'd3 SHALL return to IDLE on the next edge.
REQ-015 IDLE: any mX_req sampled high -> latch winner, drive grant, go to BUS on the same edge.
REQ-016 BUS: s_req=1; s_we, s_addr and s_wdata are registered copies of the winner's inputs, captured at the IDLE->BUS edge and held stable until exit from BUS.
REQ-017 BUS: s_ack sampled high -> capture s_rdata into winner's mX_rdata, assert winner's mX_ready for exactly one cycle, go to DONE.
REQ-018 BUS SHALL wait indefinitely for s_ack; no timeout.
REQ-019 DONE: s_req=0, grant held; all requests ignored for one cycle (turnaround, lets master drop req); then go to IDLE, grant=00.
REQ-020 Minimum latency: req high at edge k -> s_req high after edge k; s_ack at edge k+1 -> mX_ready high during cycle after edge k+1; next grant no earlier than edge k+3.
REQ-021 mX_rdata SHALL hold its last captured value until the next completed transaction for that master; writes SHALL also update mX_rdata with s_rdata.
REQ-022 Non-winning master's ready SHALL remain 0; its req stays pending without loss.
REQ-023 mX_req deasserted by a master while it owns BUS SHALL NOT abort the transaction.
REQ-024 s_ack outside BUS SHALL be ignored.
REQ-025 grant SHALL never have both bits set.

Reset
REQ-026 reset low (asynchronous) -> state IDLE, grant=00, s_req=0, s_we=0, s_addr=0, s_wdata=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, priority pointer = m0.
REQ-027 reset asserted mid-BUS SHALL abandon the transaction with no ready pulse; outputs take reset values immediately.
REQ-028 First arbitration SHALL occur at the first rising edge after reset release.

Configuration
REQ-029 Macro MIO_ARB_RR_EN defined: round-robin; pointer favours the master not granted last, updated at the BUS->DONE edge; simultaneous requests alternate.
REQ-030 MIO_ARB_RR_EN undefined: fixed priority, m0 (CPU) always wins simultaneous requests; pointer logic absent.

Verification
REQ-031 Single read: m0_req=1, m0_addr=0x0000_0040, s_ack 1 cycle after s_req with s_rdata=0xDEAD_BEEF -> s_addr=0x40, m0_ready one pulse, m0_rdata=0xDEAD_BEEF, grant 01 then 00.
REQ-032 Write: m1_req=1, m1_we=1, m1_addr=0x100, m1_wdata=0x1234_5678 -> s_we=1, s_wdata=0x1234_5678 stable until s_ack; m1_ready one pulse; m0_ready stays 0.
REQ-033 Contention: m0_req and m1_req held high for 4 transactions -> RR_EN: grants 01,10,01,10; without: 01,01,01,01.
REQ-034 Stall: s_ack withheld 20 cycles -> s_req, s_addr, grant stable for all 20 cycles; single ready pulse after ack.
REQ-035 Reset mid-BUS: reset low 2 cycles after grant -> s_req=0, grant=00, no ready pulse; after release, pending m1_req granted within 1 edge.
REQ-036 Spurious s_ack=1 in IDLE with no requests -> no ready pulse, state_out stays 0.

Source files
------------

// File: rtl/mio_arbiter.sv
// mio_arbiter: two-master arbiter (CPU = m0, fetch engine = m1) for one shared memory port.
// Define MIO_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
`default_nettype none

module mio_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  output logic [1:0]    grant,
  output logic [1:0]    state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   pick_m1;

`ifdef MIO_ARB_RR_EN
  // ptr set means m1 wins a tie; it points away from the last completed owner.
  logic ptr;
  assign pick_m1 = m1_req & (~m0_req | ptr);
`else
  assign pick_m1 = m1_req & ~m0_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = (m0_req || m1_req) ? BUS : IDLE;
      BUS:     state_next = s_ack ? DONE : BUS;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign s_req     = (state == BUS);
  assign state_out = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant    <= 2'b00;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
`ifdef MIO_ARB_RR_EN
      ptr      <= 1'b0;
`endif
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant   <= pick_m1 ? 2'b10 : 2'b01;
            s_we    <= pick_m1 ? m1_we : m0_we;
            s_addr  <= pick_m1 ? m1_addr : m0_addr;
            s_wdata <= pick_m1 ? m1_wdata : m0_wdata;
          end
        end
        BUS: begin
          if (s_ack) begin
            if (grant[1]) begin
              m1_rdata <= s_rdata;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= s_rdata;
              m0_ready <= 1'b1;
            end
`ifdef MIO_ARB_RR_EN
            ptr <= grant[0];
`endif
          end
        end
        default: grant <= 2'b00;
      endcase
    end
  end

endmodule

`default_nettype wire
